sample_delay_aligner: RTL and testbench
=======================================

// Module: sample_delay_aligner
// PURPOSE
//  Parametrised, runtime-programmable delay buffer that aligns the raw sample stream with the
//  PSS detector decision before frame_sync, replacing fixed per-FFT_LEN register delay lines.
//  Delay is counted in valid samples (not clock cycles), so gaps in tvalid do not skew alignment.
//  Carries N_CH parallel IQ channels plus a user sideband.
//  Re-primes on every delay change and suppresses output until the new alignment is valid.
// PARAMETERS
//  IN_DW          32   width of one IQ sample (re in low half, im in high half)
//  N_CH           1    parallel channels sharing one delay
//  USER_DW        1    sideband width delayed with the data (e.g. marker strobe)
//  MAX_DELAY      64   largest supported delay in samples; RAM depth DEPTH = 2**$clog2(MAX_DELAY+1)
//  DEFAULT_DELAY  14   delay in force after reset; must be <= MAX_DELAY
//  localparam DLY_W = $clog2(MAX_DELAY+1)
// PORTS
//  clk_i               in   1              clock
//  reset_ni            in   1              asynchronous reset, active low
//  s_axis_in_tdata     in   N_CH*IN_DW     input samples, channel k at [k*IN_DW +: IN_DW]
//  s_axis_in_tuser     in   USER_DW        sideband, delayed with data
//  s_axis_in_tvalid    in   1              input valid; no backpressure
//  delay_i             in   DLY_W+1        requested delay in samples
//  delay_load_i        in   1              1-cycle strobe: latch delay_i, re-prime
//  m_axis_out_tdata    out  N_CH*IN_DW     delayed samples
//  m_axis_out_tuser    out  USER_DW        delayed sideband
//  m_axis_out_tvalid   out  1              delayed valid
//  aligned_o           out  1              1 while in RUN
//  fill_count_o        out  DLY_W          samples written since last (re)prime, saturates at delay
//  delay_err_o         out  1              sticky: last loaded delay exceeded MAX_DELAY (clamped)
// BEHAVIOUR
//  Reset (async, reset_ni=0): all outputs 0; wr_ptr=0, fill_count=0, delay=DEFAULT_DELAY,
//   state FILL (RUN if DEFAULT_DELAY=0). RAM contents not cleared; never read before written.
//  Storage: circular RAM of DEPTH words, word = {tuser, tdata}; wr_ptr advances by 1 mod DEPTH
//   only on s_axis_in_tvalid. Read address = (wr_ptr - delay) mod DEPTH, read in the same cycle.
//  Output latency: exactly 1 clock. On a valid input cycle in RUN, the next cycle presents the
//   sample received delay valid samples earlier with m_axis_out_tvalid=1; otherwise tvalid=0.
//   tdata/tuser hold their last value when tvalid=0.
//  delay=0: registered passthrough (input of cycle n appears at n+1), RAM bypassed.
//  States:
//   FILL: each valid input increments fill_count; tvalid forced 0. When a valid input arrives
//    with fill_count == delay (i.e. delay samples already stored) -> RUN in that same cycle and
//    that input produces output. delay=0 -> RUN immediately.
//   RUN : output follows input valid pattern, 1 cycle later.
//   Any state + delay_load_i -> FILL with fill_count=0, delay=min(delay_i, MAX_DELAY),
//    delay_err_o = (delay_i > MAX_DELAY). The input sample in the load cycle (if valid) is the
//    first sample of the new fill (fill_count=1 next cycle). Output of that cycle: tvalid=0.
//  wr_ptr is not reset on load; stored history is simply not trusted until refilled.
//  aligned_o = (state==RUN), registered, changes with state.
//  fill_count_o saturates at delay, stays there in RUN; cleared on load.
//  No input backpressure: every valid input is accepted; no overflow possible since writes
//   and reads move in lockstep.
//  Reset asserted mid-operation: immediate async return to reset values; in-flight samples lost.
//  Target 120-400 lines; one inferred simple-dual-port RAM, no multipliers.
// TESTING
//  1 Reset, DEFAULT_DELAY=14, ramp data 1,2,3.. every cycle -> first tvalid on cycle after
//    sample 15 enters, carrying 1; aligned_o rises same cycle; then 2,3,.. continuous.
//  2 Same ramp, tvalid 1-of-3 cycles -> output is ramp delayed 14 valid samples, tvalid pattern
//    identical to input shifted 1 cycle; no value skipped or repeated.
//  3 In RUN load delay_i=5 with valid sample 100 same cycle -> tvalid 0 until sample 105
//    enters, then outputs 100 next cycle; fill_count_o reads 5; delay_err_o=0.
//  4 Load delay_i=MAX_DELAY+7 -> delay_err_o=1, effective delay MAX_DELAY; next load of 3 clears it.
//  5 Load delay_i=0 -> aligned_o=1 next cycle, output = input delayed 1 clock, tuser intact.
//  6 N_CH=2, USER_DW=1, marker on sample 20: assert reset_ni low mid-stream for 3 cycles ->
//    outputs 0 immediately; after release refill DEFAULT_DELAY samples before first tvalid;
//    marker appears exactly DEFAULT_DELAY samples after its input on both channels' word.

Source files
------------

// File: rtl/sample_delay_aligner.sv
// Sample-count delay line: aligns N_CH IQ channels plus a sideband by a programmable number
// of valid samples, re-priming on every delay load and muting output until refilled.
module sample_delay_aligner #(
    parameter int IN_DW         = 32,
    parameter int N_CH          = 1,
    parameter int USER_DW       = 1,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 14,
    localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [N_CH*IN_DW-1:0] s_axis_in_tdata,
    input  logic [USER_DW-1:0]    s_axis_in_tuser,
    input  logic                  s_axis_in_tvalid,
    input  logic [DLY_W:0]        delay_i,
    input  logic                  delay_load_i,
    output logic [N_CH*IN_DW-1:0] m_axis_out_tdata,
    output logic [USER_DW-1:0]    m_axis_out_tuser,
    output logic                  m_axis_out_tvalid,
    output logic                  aligned_o,
    output logic [DLY_W-1:0]      fill_count_o,
    output logic                  delay_err_o
);
    localparam int DEPTH = 2 ** DLY_W;
    localparam int DW    = N_CH * IN_DW;
    localparam int WW    = USER_DW + DW;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (DEFAULT_DELAY == 0) ? RUN : FILL;

    state_t           state, state_next;
    logic [DLY_W-1:0] delay_q;
    logic [DLY_W-1:0] fill_q, fill_next;
    logic [DLY_W-1:0] wr_ptr, rd_addr;
    logic [DLY_W-1:0] load_delay;
    logic             load_err;
    logic             fire;
    logic [WW-1:0]    in_word;
    logic [WW-1:0]    out_word;
    logic             out_valid;
    logic             err_q;
    logic [WW-1:0]    mem [DEPTH];

    assign in_word    = {s_axis_in_tuser, s_axis_in_tdata};
    assign load_err   = (delay_i > (DLY_W + 1)'(MAX_DELAY));
    assign load_delay = load_err ? DLY_W'(MAX_DELAY) : delay_i[DLY_W-1:0];
    // Modulo-DEPTH subtraction; DEPTH is a power of two so the wrap is free.
    assign rd_addr    = wr_ptr - delay_q;

    // NOTE: always_comb assigns every output a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        fill_next  = fill_q;
        fire       = 1'b0;
        if (delay_load_i) begin
            state_next = (load_delay == '0) ? RUN : FILL;
            fill_next  = (s_axis_in_tvalid && load_delay != '0) ? DLY_W'(1) : '0;
        end else if (s_axis_in_tvalid) begin
            case (state)
                FILL: begin
                    if (fill_q == delay_q) begin
                        state_next = RUN;
                        fire       = 1'b1;
                    end else begin
                        fill_next = fill_q + DLY_W'(1);
                    end
                end
                RUN: fire = 1'b1;
                default: state_next = FILL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= RESET_STATE;
            fill_q  <= '0;
            delay_q <= DLY_W'(DEFAULT_DELAY);
            err_q   <= 1'b0;
            wr_ptr  <= '0;
        end else begin
            state  <= state_next;
            fill_q <= fill_next;
            if (delay_load_i) begin
                delay_q <= load_delay;
                err_q   <= load_err;
            end
            if (s_axis_in_tvalid) begin
                wr_ptr <= wr_ptr + DLY_W'(1);
            end
        end
    end

    // NOTE: the history RAM has no reset; entries are only read after being written since the last prime.
    always_ff @(posedge clk_i) begin
        if (s_axis_in_tvalid) begin
            mem[wr_ptr] <= in_word;
        end
    end

    // Zero delay bypasses the RAM so the sample just arriving is presented next cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_word  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                out_word <= (delay_q == '0) ? in_word : mem[rd_addr];
            end
        end
    end

    assign m_axis_out_tdata  = out_word[DW-1:0];
    assign m_axis_out_tuser  = out_word[WW-1:DW];
    assign m_axis_out_tvalid = out_valid;
    assign aligned_o         = (state == RUN);
    assign fill_count_o      = fill_q;
    assign delay_err_o       = err_q;

endmodule

// File: tb/tb_sample_delay_aligner.sv
// Bench for sample_delay_aligner: reference history model feeding an expectation queue,
// a table of delay loads, and hand-written reset/marker/alignment sequences.
module tb_sample_delay_aligner;
    localparam int IN_DW     = 32;
    localparam int N_CH      = 2;
    localparam int USER_DW   = 1;
    localparam int MAX_DELAY = 64;
    localparam int DEF_DLY   = 14;
    localparam int DLY_W     = $clog2(MAX_DELAY + 1);
    localparam int DW        = N_CH * IN_DW;
    localparam int WW        = USER_DW + DW;

    logic              clk = 1'b0;
    logic              reset_ni = 1'b1;
    logic [DW-1:0]     in_tdata = '0;
    logic [USER_DW-1:0] in_tuser = '0;
    logic              in_tvalid = 1'b0;
    logic [DLY_W:0]    delay_in = '0;
    logic              delay_load = 1'b0;
    logic [DW-1:0]     out_tdata;
    logic [USER_DW-1:0] out_tuser;
    logic              out_tvalid;
    logic              aligned;
    logic [DLY_W-1:0]  fill_count;
    logic              delay_err;

    sample_delay_aligner #(
        .IN_DW(IN_DW), .N_CH(N_CH), .USER_DW(USER_DW),
        .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(DEF_DLY)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .s_axis_in_tdata(in_tdata), .s_axis_in_tuser(in_tuser), .s_axis_in_tvalid(in_tvalid),
        .delay_i(delay_in), .delay_load_i(delay_load),
        .m_axis_out_tdata(out_tdata), .m_axis_out_tuser(out_tuser), .m_axis_out_tvalid(out_tvalid),
        .aligned_o(aligned), .fill_count_o(fill_count), .delay_err_o(delay_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [WW-1:0] word;
        logic          aligned;
        int            fill;
        logic          err;
    } exp_t;

    typedef struct {
        logic [DLY_W:0]   dly;
        int               gap;
        logic             exp_err;
        logic [DLY_W-1:0] exp_eff;
    } vec_t;

    exp_t          exp_q[$];
    logic [WW-1:0] hist[$];
    int            m_delay;
    logic          m_run;
    logic          m_err;
    logic [WW-1:0] m_last;
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    int            s_ctr;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] s);
        return {s + 32'h1000_0000, s};
    endfunction

    // Reference model: the output is the sample seen delay valid samples ago since the last prime.
    task automatic step(input logic v, input logic [31:0] s, input logic u,
                        input logic ld, input logic [DLY_W:0] d);
        exp_t e;
        @(negedge clk);
        in_tvalid  = v;
        in_tdata   = mk(s);
        in_tuser   = u;
        delay_load = ld;
        delay_in   = d;
        e.valid    = 1'b0;
        if (ld) begin
            m_err   = (int'(d) > MAX_DELAY);
            m_delay = m_err ? MAX_DELAY : int'(d);
            hist.delete();
            m_run   = (m_delay == 0);
            if (v && m_delay != 0) hist.push_back({u, mk(s)});
        end else if (v) begin
            hist.push_back({u, mk(s)});
            if (hist.size() > m_delay) begin
                m_last  = hist.pop_front();
                e.valid = 1'b1;
                m_run   = 1'b1;
            end
        end
        e.word    = m_last;
        e.aligned = m_run;
        e.fill    = hist.size();
        e.err     = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1;
        reset_ni   = 1'b0;
        in_tvalid  = 1'b0;
        delay_load = 1'b0;
        #1;
        check("rst_tvalid", WW'(out_tvalid), '0);
        check("rst_tdata", WW'(out_tdata), '0);
        check("rst_tuser", WW'(out_tuser), '0);
        check("rst_aligned", WW'(aligned), '0);
        check("rst_fill", WW'(fill_count), '0);
        check("rst_err", WW'(delay_err), '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        exp_q.delete();
        hist.delete();
        m_delay = DEF_DLY;
        m_run   = 1'b0;
        m_err   = 1'b0;
        m_last  = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("tvalid", WW'(out_tvalid), WW'(mon_e.valid));
            check("out_word", {out_tuser, out_tdata}, mon_e.word);
            check("aligned", WW'(aligned), WW'(mon_e.aligned));
            check("fill_count", WW'(fill_count), WW'(mon_e.fill));
            check("delay_err", WW'(delay_err), WW'(mon_e.err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{dly: 8'd5,  gap: 2, exp_err: 1'b0, exp_eff: 7'd5};
        vecs[1] = '{dly: 8'd71, gap: 1, exp_err: 1'b1, exp_eff: 7'd64};
        vecs[2] = '{dly: 8'd3,  gap: 3, exp_err: 1'b0, exp_eff: 7'd3};
        vecs[3] = '{dly: 8'd0,  gap: 3, exp_err: 1'b0, exp_eff: 7'd0};
        vecs[4] = '{dly: 8'd1,  gap: 2, exp_err: 1'b0, exp_eff: 7'd1};
        vecs[5] = '{dly: 8'd64, gap: 1, exp_err: 1'b0, exp_eff: 7'd64};
        vecs[6] = '{dly: 8'd71, gap: 1, exp_err: 1'b1, exp_eff: 7'd64};

        do_reset();

        // Continuous ramp from reset: sample 15 releases sample 1.
        for (int s = 1; s <= 14; s++) step(1'b1, 32'(s), 1'(s >> 2), 1'b0, '0);
        check("t1_not_aligned", WW'(aligned), '0);
        check("t1_fill14", WW'(fill_count), WW'(14));
        step(1'b1, 32'd15, 1'b1, 1'b0, '0);
        check("t1_first_valid", WW'(out_tvalid), WW'(1));
        check("t1_first_data", WW'(out_tdata[31:0]), WW'(1));
        check("t1_aligned_rise", WW'(aligned), WW'(1));
        for (int s = 16; s <= 24; s++) step(1'b1, 32'(s), 1'(s >> 2), 1'b0, '0);

        // Same ramp with valid on one cycle in three.
        do_reset();
        s_ctr = 1;
        for (int c = 0; c < 66; c++) begin
            step((c % 3) == 0, 32'(s_ctr), 1'(s_ctr >> 2), 1'b0, '0);
            if ((c % 3) == 0) s_ctr++;
        end

        // Reload delay 5 in RUN with sample 100 in the load cycle.
        step(1'b1, 32'd100, 1'b0, 1'b1, 8'd5);
        for (int s = 101; s <= 104; s++) step(1'b1, 32'(s), 1'(s >> 2), 1'b0, '0);
        check("t3_fill5", WW'(fill_count), WW'(5));
        check("t3_still_muted", WW'(out_tvalid), '0);
        step(1'b1, 32'd105, 1'b0, 1'b0, '0);
        check("t3_first_valid", WW'(out_tvalid), WW'(1));
        check("t3_first_data", WW'(out_tdata[31:0]), WW'(100));
        check("t3_no_err", WW'(delay_err), '0);

        // Table of delay loads, each followed by a streamed burst.
        s_ctr = 200;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 32'(s_ctr), 1'(s_ctr >> 2), 1'b1, vecs[i].dly);
            s_ctr++;
            check("load_err", WW'(delay_err), WW'(vecs[i].exp_err));
            if (vecs[i].dly == 0) check("zero_dly_aligned", WW'(aligned), WW'(1));
            for (int c = 0; c < 80; c++) begin
                step((c % vecs[i].gap) == 0, 32'(s_ctr), 1'(s_ctr >> 2), 1'b0, '0);
                if ((c % vecs[i].gap) == 0) s_ctr++;
            end
            check("fill_saturated", WW'(fill_count), WW'(vecs[i].exp_eff));
        end

        // Reset mid-stream, then refill with a marker on sample 20.
        do_reset();
        for (int s = 1; s <= 40; s++) begin
            step(1'b1, 32'(s), (s == 20), 1'b0, '0);
            if (s == 14) check("t6_muted_after14", WW'(out_tvalid), '0);
            if (s == 34) begin
                check("t6_marker", WW'(out_tuser), WW'(1));
                check("t6_marker_word", WW'(out_tdata), WW'(mk(32'd20)));
            end
        end
        step(1'b0, 32'd0, 1'b0, 1'b0, '0);
        step(1'b0, 32'd0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
